// File: rtl/fm0_decoder.sv
// FM0 backscatter decoder: edge-interval classifier driving an IDLE/BOUND/HALF FSM; FM0_DECODER_SYNC_EN adds a 2-flop input synchronizer.
// Latency: out_valid 2 clocks after the completing in_fm0 transition (4 with FM0_DECODER_SYNC_EN).
// Backpressure: none; out_valid/out_err/out_done are single-cycle pulses the consumer must take when asserted.
module fm0_decoder #(
  parameter int SYM_PERIOD = 16,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic in_fm0,
  output logic out_bit,
  output logic out_valid,
  output logic out_err,
  output logic out_done
);

  localparam logic [CNT_W-1:0] SHORT_MIN = CNT_W'(SYM_PERIOD / 4);
  localparam logic [CNT_W-1:0] LONG_MIN  = CNT_W'((3 * SYM_PERIOD) / 4);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'((5 * SYM_PERIOD) / 4);
  localparam logic [CNT_W-1:0] TMO_VAL   = CNT_W'((5 * SYM_PERIOD) / 4 + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BOUND = 2'd1,
    S_HALF  = 2'd2
  } state_t;

  logic             line_in;
  logic             smp;
  logic             smp_d;
  logic             edge_det;
  logic [CNT_W-1:0] cnt;
  logic             is_short;
  logic             is_long;
  logic             timeout_hit;
  state_t           state;
  state_t           state_nxt;
  logic             valid_nxt;
  logic             bit_nxt;
  logic             err_nxt;
  logic             done_nxt;

`ifdef FM0_DECODER_SYNC_EN
  logic sync1;
  logic sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= in_fm0;
      sync2 <= sync1;
    end
  end

  assign line_in = sync2;
`else
  assign line_in = in_fm0;
`endif

  // Sample registers keep tracking while disabled so re-enabling never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp   <= 1'b0;
      smp_d <= 1'b0;
    end else begin
      smp   <= line_in;
      smp_d <= smp;
    end
  end

  assign edge_det = en & (smp ^ smp_d);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (edge_det) begin
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign is_short    = (cnt >= SHORT_MIN) && (cnt < LONG_MIN);
  assign is_long     = (cnt >= LONG_MIN) && (cnt <= LONG_MAX);
  // An edge landing on the first over-range cycle takes priority over the timeout.
  assign timeout_hit = (cnt == TMO_VAL) && !edge_det;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (edge_det) state_nxt = S_BOUND;
        end
        S_BOUND: begin
          if (edge_det) begin
            if (is_long)       state_nxt = S_BOUND;
            else if (is_short) state_nxt = S_HALF;
            else               state_nxt = S_IDLE;
          end else if (timeout_hit) begin
            state_nxt = S_IDLE;
          end
        end
        S_HALF: begin
          if (edge_det) begin
            if (is_short) state_nxt = S_BOUND;
            else          state_nxt = S_IDLE;
          end else if (timeout_hit) begin
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    valid_nxt = 1'b0;
    bit_nxt   = 1'b0;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    if (en) begin
      case (state)
        S_BOUND: begin
          if (edge_det) begin
            if (is_long) begin
              valid_nxt = 1'b1;
              bit_nxt   = 1'b1;
            end else if (!is_short) begin
              err_nxt = 1'b1;
            end
          end else if (timeout_hit) begin
            done_nxt = 1'b1;
          end
        end
        S_HALF: begin
          if (edge_det) begin
            if (is_short) begin
              valid_nxt = 1'b1;
              bit_nxt   = 1'b0;
            end else begin
              err_nxt = 1'b1;
            end
          end else if (timeout_hit) begin
            err_nxt = 1'b1;
          end
        end
        default: begin
          valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_done  <= 1'b0;
    end else begin
      out_valid <= valid_nxt;
      out_err   <= err_nxt;
      out_done  <= done_nxt;
      if (valid_nxt) out_bit <= bit_nxt;
    end
  end

endmodule
